// File: rtl/fb_table_server.sv
// F (cost) / B (backpointer) table server for the formant DP: 2-cycle F reads, per-column writes.
// Define FB_TRACE_EN to build the backward boundary walker over the B table.
module fb_table_server #(
    parameter int BIT_WIDTH = 32,
    parameter int I         = 160,
    parameter int FORMANTS  = 5,
    localparam int IW = $clog2(I),
    localparam int KW = $clog2(FORMANTS),
    localparam int JW = IW + 1,
    localparam int N  = FORMANTS * I,
    localparam int AW = $clog2(N)
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 clear_in,
    input  logic [IW-1:0]        i_cur,
    input  logic                 begin_iter,
    input  logic [KW-1:0]        k_req,
    input  logic signed [JW-1:0] j_req,
    output logic [BIT_WIDTH-1:0] f_prev,
    output logic [BIT_WIDTH-1:0] f_old,
    input  logic [KW-1:0]        k_write,
    input  logic [BIT_WIDTH-1:0] f_data,
    input  logic signed [JW-1:0] b_data,
    input  logic                 wr_valid,
    input  logic                 trace_start,
    input  logic [KW-1:0]        trace_k,
    input  logic [IW-1:0]        trace_i,
    output logic                 bound_valid,
    output logic [KW-1:0]        bound_k,
    output logic signed [JW-1:0] bound_j,
    output logic                 trace_busy,
    output logic                 trace_done
);
    localparam logic [BIT_WIDTH-1:0] INF = {BIT_WIDTH{1'b1}};

    function automatic logic [AW-1:0] idx(input logic [KW-1:0] k, input logic [IW-1:0] i);
        return AW'(k) * AW'(I) + AW'(i);
    endfunction

    logic [BIT_WIDTH-1:0] f_mem [N];
    logic signed [JW-1:0] b_mem [N];
    logic [N-1:0]         valid_q, valid_d;
    logic [IW-1:0]        i_lat_q;
    logic                 wr_ok_s, prev_rd_s, prev_zero_s, old_rd_s;
    logic [AW-1:0]        wr_addr_s, prev_addr_s, old_addr_s;
    logic [BIT_WIDTH-1:0] prev_data_q, old_data_q, f_prev_q, f_old_q;
    logic                 prev_ok_q, prev_zero_q, old_ok_q;

    assign wr_ok_s   = wr_valid && ((KW+1)'(k_write) < (KW+1)'(FORMANTS));
    assign wr_addr_s = idx(k_write, i_lat_q);
    assign old_rd_s  = (KW+1)'(k_req) < (KW+1)'(FORMANTS);
    assign old_addr_s = old_rd_s ? idx(k_req, i_lat_q) : '0;

    // Decode the f_prev request into a table address or one of the fixed answers.
    always_comb begin
        prev_zero_s = 1'b0;
        prev_rd_s   = 1'b0;
        prev_addr_s = '0;
        if (k_req == '0 || (KW+1)'(k_req) > (KW+1)'(FORMANTS)) begin
            prev_rd_s = 1'b0;
        end else if (j_req[JW-1]) begin
            prev_zero_s = (k_req == KW'(1)) && (j_req == '1);
        end else if ({1'b0, j_req[IW-1:0]} < (IW+1)'(I)) begin
            prev_rd_s   = 1'b1;
            prev_addr_s = idx(k_req - KW'(1), j_req[IW-1:0]);
        end else begin
            prev_rd_s = 1'b0;
        end
    end

    // Clear drops every entry first so a simultaneous write survives.
    always_comb begin
        valid_d = clear_in ? '0 : valid_q;
        if (wr_ok_s) begin
            valid_d[wr_addr_s] = 1'b1;
        end else begin
            valid_d = valid_d;
        end
    end

    // Table storage; contents are only meaningful where the valid bit is set.
    always_ff @(posedge clk_in) begin
        if (wr_ok_s) begin
            f_mem[wr_addr_s] <= f_data;
            b_mem[wr_addr_s] <= b_data;
        end
    end

    // Valid bits and the column latched by begin_iter.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q <= '0;
            i_lat_q <= '0;
        end else begin
            valid_q <= valid_d;
            i_lat_q <= begin_iter ? i_cur : i_lat_q;
        end
    end

    // Read pipeline: array read on the request edge (no write forwarding), INF gating on the next.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            prev_data_q <= '0;
            prev_ok_q   <= 1'b0;
            prev_zero_q <= 1'b0;
            old_data_q  <= '0;
            old_ok_q    <= 1'b0;
            f_prev_q    <= INF;
            f_old_q     <= INF;
        end else begin
            prev_data_q <= f_mem[prev_addr_s];
            prev_ok_q   <= prev_rd_s && valid_q[prev_addr_s];
            prev_zero_q <= prev_zero_s;
            old_data_q  <= f_mem[old_addr_s];
            old_ok_q    <= old_rd_s && valid_q[old_addr_s];
            f_prev_q    <= prev_zero_q ? '0 : (prev_ok_q ? prev_data_q : INF);
            f_old_q     <= old_ok_q ? old_data_q : INF;
        end
    end

    assign f_prev = f_prev_q;
    assign f_old  = f_old_q;

`ifdef FB_TRACE_EN
    typedef enum logic [2:0] {TR_IDLE, TR_RD, TR_WAIT, TR_EMIT, TR_DONE} tr_state_e;
    tr_state_e            state_q, state_d;
    logic [KW-1:0]        tr_k_q;
    logic [IW-1:0]        tr_i_q;
    logic signed [JW-1:0] tr_b_q;
    logic                 tr_bv_q, tr_cnt_q, tr_rd_ok_s, tr_last_s;
    logic [AW-1:0]        tr_addr_s;
    logic                 bound_valid_d, trace_busy_d, trace_done_d;
    logic                 bound_valid_q, trace_busy_q, trace_done_q;
    logic [KW-1:0]        bound_k_d, bound_k_q;
    logic signed [JW-1:0] bound_j_d, bound_j_q;

    assign tr_rd_ok_s = ((KW+1)'(tr_k_q) < (KW+1)'(FORMANTS)) && ({1'b0, tr_i_q} < (IW+1)'(I));
    assign tr_addr_s  = tr_rd_ok_s ? idx(tr_k_q, tr_i_q) : '0;
    assign tr_last_s  = (tr_k_q == '0) || !tr_bv_q || tr_b_q[JW-1];

    // Trace state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= TR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Trace next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TR_IDLE: state_d = trace_start ? TR_RD : TR_IDLE;
            TR_RD:   state_d = TR_WAIT;
            TR_WAIT: state_d = tr_cnt_q ? TR_EMIT : TR_WAIT;
            TR_EMIT: state_d = tr_last_s ? TR_DONE : TR_RD;
            TR_DONE: state_d = TR_IDLE;
            default: state_d = TR_IDLE;
        endcase
    end

    // Trace cursor and private B read path.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tr_k_q   <= '0;
            tr_i_q   <= '0;
            tr_b_q   <= '0;
            tr_bv_q  <= 1'b0;
            tr_cnt_q <= 1'b0;
        end else begin
            case (state_q)
                TR_IDLE: begin
                    if (trace_start) begin
                        tr_k_q <= trace_k;
                        tr_i_q <= trace_i;
                    end
                end
                TR_RD: begin
                    tr_b_q   <= b_mem[tr_addr_s];
                    tr_bv_q  <= tr_rd_ok_s && valid_q[tr_addr_s];
                    tr_cnt_q <= 1'b0;
                end
                TR_WAIT: tr_cnt_q <= 1'b1;
                TR_EMIT: begin
                    if (!tr_last_s) begin
                        tr_k_q <= tr_k_q - KW'(1);
                        tr_i_q <= tr_b_q[IW-1:0];
                    end
                end
                default: tr_cnt_q <= 1'b0;
            endcase
        end
    end

    // Trace outputs decoded from the state being entered, then registered.
    always_comb begin
        bound_valid_d = (state_d == TR_EMIT);
        trace_busy_d  = (state_d == TR_RD) || (state_d == TR_WAIT) || (state_d == TR_EMIT);
        trace_done_d  = (state_d == TR_DONE);
        if (state_d == TR_EMIT) begin
            bound_k_d = tr_k_q;
            bound_j_d = tr_bv_q ? tr_b_q : '1;
        end else begin
            bound_k_d = '0;
            bound_j_d = '0;
        end
    end

    // Trace output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bound_valid_q <= 1'b0;
            trace_busy_q  <= 1'b0;
            trace_done_q  <= 1'b0;
            bound_k_q     <= '0;
            bound_j_q     <= '0;
        end else begin
            bound_valid_q <= bound_valid_d;
            trace_busy_q  <= trace_busy_d;
            trace_done_q  <= trace_done_d;
            bound_k_q     <= bound_k_d;
            bound_j_q     <= bound_j_d;
        end
    end

    assign bound_valid = bound_valid_q;
    assign bound_k     = bound_k_q;
    assign bound_j     = bound_j_q;
    assign trace_busy  = trace_busy_q;
    assign trace_done  = trace_done_q;
`else
    logic unused_trace_s;
    assign unused_trace_s = ^{trace_start, trace_k, trace_i, b_mem[0]};
    assign bound_valid = 1'b0;
    assign bound_k     = '0;
    assign bound_j     = '0;
    assign trace_busy  = 1'b0;
    assign trace_done  = 1'b0;
`endif
endmodule
